// File: rtl/stream_arbiter_pkg.sv
// stream_arbiter_pkg: shared FSM state encodings and the clog2 helper used to validate SELW.
//   ST_IDLE  round-robin scan from ptr
//   ST_LOCK  current owner keeps the grant until HOLD beats or it drops valid
package stream_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int CNT_W = 5;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_arbiter_rr_picker.sv
// stream_arbiter_rr_picker: combinational rotated priority encoder picking the first request at or after ptr.
//   req  in   N     request vector
//   ptr  in   SELW  index with highest priority
//   gnt  out  N     one-hot grant (zero when nothing is requested)
//   idx  out  SELW  index of the granted request
//   any  out  1     at least one request is present
module stream_arbiter_rr_picker #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    localparam logic [SELW:0] N_W = (SELW + 1)'(N);

    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [SELW-1:0] first;
    logic [SELW:0]   sum;

    always_comb begin
        // Shifting the doubled vector right by ptr puts req[ptr] at bit 0,
        // so a plain lowest-bit-first encode gives round-robin order.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        first = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) first = SELW'(j);
        sum = {1'b0, ptr} + {1'b0, first};
        idx = (sum >= N_W) ? SELW'(sum - N_W) : SELW'(sum);
        any = |req;
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: N-way round-robin arbiter with optional HOLD-beat grant lock and a registered, source-tagged output.
//   iCLK, iRST   clock (rising) and asynchronous active-low reset
//   iValid_AM    per-requester valid
//   oReady_AM    per-requester ready, at most one bit set
//   iData_AM     requester i at bits [i*WIDTH +: WIDTH]
//   oValid_BM    registered output valid
//   iReady_BM    output ready
//   oSelect_BM   registered source index of the current output beat
//   oData_BM     registered output data
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter int    N     = 4,
    parameter int    SELW  = 2,
    parameter int    HOLD  = 1,
    parameter string FIXED = "no"
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [N-1:0]         iValid_AM,
    output logic [N-1:0]         oReady_AM,
    input  logic [N*WIDTH-1:0]   iData_AM,
    output logic                 oValid_BM,
    input  logic                 iReady_BM,
    output logic [SELW-1:0]      oSelect_BM,
    output logic [WIDTH-1:0]     oData_BM
);

    localparam bit IS_FIXED = (FIXED == "yes");

    if (SELW != clog2(N)) begin : g_bad_selw
        $error("stream_arbiter: SELW must equal clog2(N)");
    end

    state_t           state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [N-1:0]     pick_gnt;
    logic [SELW-1:0]  pick_idx;
    logic             pick_any;
    logic             en, locked, gx, acc;
    logic [SELW-1:0]  g;

    function automatic logic [SELW-1:0] nxt(input logic [SELW-1:0] x);
        return (x == SELW'(N - 1)) ? '0 : x + SELW'(1);
    endfunction

    stream_arbiter_rr_picker #(.N(N), .SELW(SELW)) u_picker (
        .req (iValid_AM),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        en        = !valid_q || iReady_BM;
        locked    = (state_q == ST_LOCK);
        g         = locked ? owner_q : pick_idx;
        gx        = locked ? iValid_AM[owner_q] : pick_any;
        acc       = gx && en;
        oReady_AM = acc ? (locked ? (N'(1) << owner_q) : pick_gnt) : '0;
        valid_d   = acc ? 1'b1 : (iReady_BM ? 1'b0 : valid_q);
        sel_d     = acc ? g : sel_q;
        data_d    = acc ? iData_AM[g*WIDTH +: WIDTH] : data_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        if (!locked) begin
            if (acc) begin
                if (HOLD == 1) begin
                    ptr_d = nxt(g);
                end else begin
                    state_d = ST_LOCK;
                    owner_d = g;
                    cnt_d   = CNT_W'(1);
                end
            end
        end else if (!iValid_AM[owner_q]) begin
            // Owner went away: release without granting anyone this cycle.
            state_d = ST_IDLE;
            ptr_d   = nxt(owner_q);
        end else if (acc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(HOLD)) begin
                state_d = ST_IDLE;
                ptr_d   = nxt(owner_q);
            end
        end
        if (IS_FIXED) ptr_d = '0;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign oValid_BM  = valid_q;
    assign oSelect_BM = sel_q;
    assign oData_BM   = data_q;

endmodule
